// File: rtl/psum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psum_pkg
// Brief    : Shared types, constants and lane arithmetic for the psum drain
// Revision : 1.0 - initial release
// ============================================================================
package psum_pkg;

    // Lane width is fixed here because the saturating adder below is sized by it
    localparam int PSUM_BW         = 16;
    localparam int DEF_COL         = 8;
    localparam int DEF_ADDR_BW     = 11;

    // SRAM strobes are active-low
    localparam logic CEN_ON = 1'b0;
    localparam logic WEN_WR = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_POP  = 3'd1,
        S_RD   = 3'd2,
        S_ACC  = 3'd3,
        S_WR   = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    // Signed add one bit wider than a lane, then clamp to the lane range
    function automatic logic [PSUM_BW-1:0] sat_add(input logic [PSUM_BW-1:0] a,
                                                   input logic [PSUM_BW-1:0] b);
        logic [PSUM_BW:0] s;
        s = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
        if (s[PSUM_BW] == s[PSUM_BW-1]) begin
            return s[PSUM_BW-1:0];
        end else if (s[PSUM_BW]) begin
            return {1'b1, {(PSUM_BW-1){1'b0}}};
        end else begin
            return {1'b0, {(PSUM_BW-1){1'b1}}};
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/psum_lane.sv
`default_nettype none
// ============================================================================
// Module   : psum_lane
// Brief    : One psum lane: saturating accumulate and write-side ReLU
// Revision : 1.0 - initial release
// ============================================================================
module psum_lane
    import psum_pkg::*;
(
    input  logic [PSUM_BW-1:0] i_vec,
    input  logic [PSUM_BW-1:0] i_q,
    input  logic               i_acc,
    input  logic               i_relu,
    output logic [PSUM_BW-1:0] o_vec_next,
    output logic [PSUM_BW-1:0] o_wr
);

    // Next held value: summed with the SRAM word only during the accumulate step
    assign o_vec_next = i_acc ? sat_add(i_vec, i_q) : i_vec;

    // ReLU acts on the already-saturated held value
    assign o_wr = (i_relu && i_vec[PSUM_BW-1]) ? '0 : i_vec;

endmodule
`default_nettype wire

// File: rtl/psum_drain.sv
`default_nettype none
// ============================================================================
// Module   : psum_drain
// Brief    : Drains OFIFO psum vectors into psum SRAM, optionally accumulating
//            (read-modify-write, saturating) and applying ReLU on write
// Revision : 1.0 - initial release
// ============================================================================
module psum_drain
    import psum_pkg::*;
#(
    parameter int COL     = DEF_COL,
    parameter int ADDR_BW = DEF_ADDR_BW
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     acc_en,
    input  logic                     relu_en,
    input  logic [ADDR_BW-1:0]       base_addr,
    input  logic [ADDR_BW-1:0]       len,
    input  logic                     ofifo_valid,
    input  logic [PSUM_BW*COL-1:0]   ofifo_out,
    output logic                     ofifo_rd,
    output logic                     sram_cen,
    output logic                     sram_wen,
    output logic [ADDR_BW-1:0]       sram_addr,
    output logic [PSUM_BW*COL-1:0]   sram_d,
    input  logic [PSUM_BW*COL-1:0]   sram_q,
    output logic                     busy,
    output logic                     done
);

    state_t                   r_state;
    state_t                   w_next;
    logic                     r_acc;
    logic                     r_relu;
    logic [ADDR_BW-1:0]       r_addr;
    logic [ADDR_BW-1:0]       r_cnt;
    logic [PSUM_BW*COL-1:0]   r_vec;
    logic [PSUM_BW*COL-1:0]   w_vec_next;
    logic [PSUM_BW*COL-1:0]   w_wr_data;
    logic                     w_in_acc;

    assign w_in_acc = (r_state == S_ACC);

    generate
        for (genvar gi = 0; gi < COL; gi++) begin : g_lane
            psum_lane u_lane (
                .i_vec      (r_vec[gi*PSUM_BW +: PSUM_BW]),
                .i_q        (sram_q[gi*PSUM_BW +: PSUM_BW]),
                .i_acc      (w_in_acc),
                .i_relu     (r_relu),
                .o_vec_next (w_vec_next[gi*PSUM_BW +: PSUM_BW]),
                .o_wr       (w_wr_data[gi*PSUM_BW +: PSUM_BW])
            );
        end
    endgenerate

    // Address and data follow registered state, so they hold while idle
    assign sram_addr = r_addr;
    assign sram_d    = w_wr_data;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Job parameters, address/count bookkeeping and the held vector
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc  <= 1'b0;
            r_relu <= 1'b0;
            r_addr <= '0;
            r_cnt  <= '0;
            r_vec  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc  <= acc_en;
                        r_relu <= relu_en;
                        r_addr <= base_addr;
                        r_cnt  <= len;
                    end
                end
                S_POP: begin
                    if (ofifo_valid) begin
                        r_vec <= ofifo_out;
                    end
                end
                S_ACC: begin
                    r_vec <= w_vec_next;
                end
                S_WR: begin
                    r_addr <= r_addr + ADDR_BW'(1);
                    r_cnt  <= r_cnt - ADDR_BW'(1);
                end
                default: ;
            endcase
        end
    end

    // Next-state and strobe decode; SRAM stays disabled outside RD/WR
    always_comb begin
        w_next   = r_state;
        ofifo_rd = 1'b0;
        sram_cen = ~CEN_ON;
        sram_wen = ~WEN_WR;
        busy     = (r_state != S_IDLE);
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (len == '0) ? S_FIN : S_POP;
                end
            end
            S_POP: begin
                ofifo_rd = ofifo_valid;
                if (ofifo_valid) begin
                    w_next = r_acc ? S_RD : S_WR;
                end
            end
            S_RD: begin
                sram_cen = CEN_ON;
                w_next   = S_ACC;
            end
            S_ACC: begin
                w_next = S_WR;
            end
            S_WR: begin
                sram_cen = CEN_ON;
                sram_wen = WEN_WR;
                w_next   = (r_cnt != ADDR_BW'(1)) ? S_POP : S_FIN;
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
